// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder built from two half-adder cells and an OR of their carries.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b;
    assign carry = a & b;
endmodule

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic w_ha0_sum;
    logic w_ha0_carry;
    logic w_ha1_carry;

    half_adder u_ha0 (.a(a),         .b(b),   .sum(w_ha0_sum), .carry(w_ha0_carry));
    half_adder u_ha1 (.a(w_ha0_sum), .b(cin), .sum(sum),       .carry(w_ha1_carry));

    assign cout = w_ha0_carry | w_ha1_carry;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder stage and a carry flop, LSB first,
// with valid/ready handshakes on both the operand and result sides.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_s_nxt;

    full_adder u_fa (
        .a   (r_a[0]),
        .b   (r_b[0]),
        .cin (r_carry),
        .sum (w_fa_sum),
        .cout(w_fa_cout)
    );

    // The sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at S[0].
    generate
        if (WIDTH == 1) begin : g_s_one
            assign w_s_nxt = w_fa_sum;
        end else begin : g_s_wide
            assign w_s_nxt = {w_fa_sum, r_s[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand load, per-bit shift/add and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_s     <= w_s_nxt;
                    r_carry <= w_fa_cout;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_s;
    assign cout      = r_carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed handshake cases plus a randomized
// stream checked against an arithmetic reference queue; also a WIDTH=1 instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = 1'b0;
    logic [0:0] b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic       out_valid1;
    logic       out_ready1 = 1'b1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y, input logic c);
        return 9'(x) + 9'(y) + 9'(c);
    endfunction

    // Present one operand pair while idle; returns #1 after the accept edge.
    task automatic start(input logic [7:0] x, input logic [7:0] y, input logic c);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, checking accept-to-valid latency and in_ready low meanwhile.
    task automatic wait_done(input string tag);
        int n;
        logic bad;
        n = 0;
        bad = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) bad = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_in_ready_low"}, 32'(bad), 32'd0);
    endtask

    // Complete the output handshake and confirm out_valid lasts a single accepted cycle.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    task automatic directed(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] e;
        e = model(x, y, c);
        start(x, y, c);
        wait_done(tag);
        chk({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[8]));
        release_result(tag);
    endtask

    initial begin
        logic [8:0] q[$];
        logic [8:0] e;
        int n_in;
        int n_out;
        int cyc;
        logic fired;

        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_w1_in_ready", 32'(in_ready1), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        directed("ff_01", 8'hFF, 8'h01, 1'b0);
        directed("5a_33", 8'h5A, 8'h33, 1'b1);
        directed("zero", 8'h00, 8'h00, 1'b0);
        directed("max", 8'hFF, 8'hFF, 1'b1);

        // Backpressure: result held while a new pair waits, then accepted one edge after exit.
        start(8'h0F, 8'h01, 1'b0);
        wait_done("bp");
        chk("bp_sum", 32'(sum), 32'h10);
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'h10);
            chk("bp_hold_no_accept", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_exit_valid", 32'(out_valid), 32'd0);
        chk("bp_exit_idle", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_accept_next", 32'(in_ready), 32'd0);
        wait_done("bp2");
        e = model(8'hAA, 8'h55, 1'b0);
        chk("bp2_sum", 32'(sum), 32'(e[7:0]));
        chk("bp2_cout", 32'(cout), 32'(e[8]));
        release_result("bp2");

        // Asynchronous reset in the middle of RUN.
        start(8'h33, 8'h44, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        directed("post_rst", 8'h10, 8'h20, 1'b0);

        // Random stream with random out_ready, checked against a FIFO of expected sums.
        n_in = 0;
        n_out = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (n_out < 200 && cyc < 20000) begin
            if (!in_valid && n_in < 200 && $urandom_range(3) != 0) begin
                in_valid = 1'b1;
                a = 8'($urandom_range(255));
                b = 8'($urandom_range(255));
                cin = 1'($urandom_range(1));
            end
            out_ready = 1'($urandom_range(1));
            fired = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_result", 32'({cout, sum}), 32'(e));
                end else begin
                    chk("rnd_spurious", 32'd1, 32'(q.size()));
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                n_in++;
                fired = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (fired) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("rnd_count", 32'(n_out), 32'd200);
        chk("rnd_queue_empty", 32'(q.size()), 32'd0);

        // WIDTH=1 instance: a single RUN cycle.
        in_valid1 = 1'b1;
        a1 = 1'b1;
        b1 = 1'b1;
        cin1 = 1'b1;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("w1_running", 32'(out_valid1), 32'd0);
        @(posedge clk);
        #1;
        chk("w1_valid", 32'(out_valid1), 32'd1);
        chk("w1_sum", 32'(sum1), 32'd1);
        chk("w1_cout", 32'(cout1), 32'd1);
        @(posedge clk);
        #1;
        chk("w1_idle", 32'(in_ready1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
